// File: rtl/lvds_tx_pkg.sv
// Shared state encoding, zero-frame macro and constants for the LVDS DDR TX framer.
// The loopback state exists only when LVDS_TX_LOOPBACK_EN is defined.
`define LVDS_TX_ZERO_FRAME(w) {(w){1'b0}}

package lvds_tx_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_TX   = 2'd1,
    ST_GAP  = 2'd2
`ifdef LVDS_TX_LOOPBACK_EN
    , ST_LB = 2'd3
`endif
  } tx_state_e;

  localparam logic [31:0] LB_FRAME_DEFAULT = 32'h8403_7048;
  localparam int          UNDERRUN_W       = 16;

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + UNDERRUN_W'(1);
  endfunction

endpackage

// File: rtl/lvds_tx_serializer.sv
// Frame serializer: phase counter, MSB-first shift register, frame strobe and boundary flag.
// The boundary flag marks the edge on which the next frame is loaded.
module lvds_tx_serializer
  import lvds_tx_pkg::*;
#(
  parameter int FRAME_W = 32,
  parameter int LANES   = 2
) (
  input  logic               i_ddr_clk,
  input  logic               i_rst,
  input  logic [FRAME_W-1:0] i_load_frame,
  output logic [LANES-1:0]   o_ddr_data,
  output logic               o_frame_strobe,
  output logic               o_boundary
);

  localparam int              PHASES  = FRAME_W / LANES;
  localparam int              PH_W    = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  logic [PH_W-1:0]    phase;
  logic [FRAME_W-1:0] r_shift;

  assign o_boundary = (phase == '0);
  assign o_ddr_data = r_shift[FRAME_W-1 -: LANES];

  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      phase          <= PH_LAST;
      r_shift        <= `LVDS_TX_ZERO_FRAME(FRAME_W);
      o_frame_strobe <= 1'b0;
    end else begin
      o_frame_strobe <= o_boundary;
      if (o_boundary) begin
        phase   <= PH_LAST;
        r_shift <= i_load_frame;
      end else begin
        phase   <= phase - PH_W'(1);
        r_shift <= {r_shift[FRAME_W-LANES-1:0], `LVDS_TX_ZERO_FRAME(LANES)};
      end
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// DDR-lane TX framer: sync/gap insertion, FIFO pull and underrun counting around the serializer.
// Define LVDS_TX_LOOPBACK_EN to add the i_debug_lb port and the loopback state.
module lvds_tx_framer
  import lvds_tx_pkg::*;
#(
  parameter int FRAME_W     = 32,
  parameter int LANES       = 2,
  parameter int SYNC_FRAMES = 10,
  parameter int GAP_W       = 4
`ifdef LVDS_TX_LOOPBACK_EN
  , parameter logic [FRAME_W-1:0] LB_FRAME = LB_FRAME_DEFAULT
`endif
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst,
  output logic [LANES-1:0]      o_ddr_data,
  input  logic                  i_fifo_empty,
  input  logic [FRAME_W-1:0]    i_fifo_data,
  output logic                  o_fifo_pull,
  input  logic [GAP_W-1:0]      i_sample_gap,
  input  logic                  i_tx_en,
`ifdef LVDS_TX_LOOPBACK_EN
  input  logic                  i_debug_lb,
`endif
  output logic                  o_tx_state,
  output logic                  o_frame_strobe,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt
);

  localparam int                SYNC_W    = $clog2(SYNC_FRAMES + 1);
  localparam logic [SYNC_W-1:0] SYNC_FULL = SYNC_W'(SYNC_FRAMES);

  tx_state_e          state, nxt_state;
  logic [SYNC_W-1:0]  sync_cnt, nxt_sync;
  logic [GAP_W-1:0]   gap_cnt, nxt_gap;
  logic [FRAME_W-1:0] load_frame;
  logic               take_word, underrun, boundary;

  // sync_cnt counts zero frames still owed; the frame that brings it to zero is the decision point.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state  = state;
    nxt_sync   = sync_cnt;
    nxt_gap    = gap_cnt;
    load_frame = `LVDS_TX_ZERO_FRAME(FRAME_W);
    take_word  = 1'b0;
    underrun   = 1'b0;
    case (state)
      ST_SYNC: begin
        if (sync_cnt > SYNC_W'(1)) nxt_sync = sync_cnt - SYNC_W'(1);
        else if (i_tx_en && !i_fifo_empty) take_word = 1'b1;
`ifdef LVDS_TX_LOOPBACK_EN
        else if (i_debug_lb && !i_tx_en) begin
          nxt_state  = ST_LB;
          load_frame = LB_FRAME;
        end
`endif
        else nxt_sync = SYNC_FULL;
      end
      ST_TX: begin
        if (!i_tx_en) begin
          nxt_state = ST_SYNC;
          nxt_sync  = SYNC_FULL;
        end else if (!i_fifo_empty) begin
          take_word = 1'b1;
        end else begin
          underrun  = 1'b1;
          nxt_state = ST_SYNC;
          nxt_sync  = SYNC_FULL;
        end
      end
      ST_GAP: begin
        if (!i_tx_en) begin
          nxt_state = ST_SYNC;
          nxt_sync  = SYNC_FULL;
        end else if (gap_cnt == '0) nxt_state = ST_TX;
        else nxt_gap = gap_cnt - GAP_W'(1);
      end
`ifdef LVDS_TX_LOOPBACK_EN
      ST_LB: begin
        if (i_debug_lb && !i_tx_en) load_frame = LB_FRAME;
        else begin
          nxt_state = ST_SYNC;
          nxt_sync  = SYNC_FULL;
        end
      end
`endif
      default: begin
        nxt_state = ST_SYNC;
        nxt_sync  = SYNC_FULL;
      end
    endcase
    // A consumed word always sets up the following gap, whether it came from SYNC or TX.
    if (take_word) begin
      load_frame = i_fifo_data;
      nxt_state  = (i_sample_gap == '0) ? ST_TX : ST_GAP;
      nxt_gap    = i_sample_gap - GAP_W'(1);
    end
  end

  // Pop on the very edge that loads the word into the shift register.
  assign o_fifo_pull = boundary && take_word;

  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_SYNC;
      sync_cnt       <= SYNC_FULL;
      gap_cnt        <= '0;
      o_tx_state     <= 1'b0;
      o_underrun_cnt <= '0;
    end else if (boundary) begin
      state      <= nxt_state;
      sync_cnt   <= nxt_sync;
      gap_cnt    <= nxt_gap;
      o_tx_state <= (nxt_state == ST_TX) || (nxt_state == ST_GAP);
      if (underrun) o_underrun_cnt <= sat_inc(o_underrun_cnt);
    end
  end

  lvds_tx_serializer #(
    .FRAME_W(FRAME_W),
    .LANES  (LANES)
  ) u_ser (
    .i_ddr_clk     (i_ddr_clk),
    .i_rst         (i_rst),
    .i_load_frame  (load_frame),
    .o_ddr_data    (o_ddr_data),
    .o_frame_strobe(o_frame_strobe),
    .o_boundary    (boundary)
  );

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: frame-level reference model, queue FIFO, directed and random phases.
// Loopback steps are compiled only when LVDS_TX_LOOPBACK_EN is defined.
module tb_lvds_tx_framer;

  localparam int          FRAME_W     = 32;
  localparam int          LANES       = 2;
  localparam int          PHASES      = FRAME_W / LANES;
  localparam int          SYNC_FRAMES = 10;
  localparam int          GAP_W       = 4;
  localparam logic [31:0] LB_WORD     = 32'h8403_7048;

  localparam int M_SYNC = 0, M_TX = 1, M_GAP = 2, M_LB = 3;

  logic               i_ddr_clk = 1'b0;
  logic               i_rst;
  logic [LANES-1:0]   o_ddr_data;
  logic               i_fifo_empty;
  logic [FRAME_W-1:0] i_fifo_data;
  logic               o_fifo_pull;
  logic [GAP_W-1:0]   i_sample_gap;
  logic               i_tx_en;
  logic               i_debug_lb;
  logic               o_tx_state;
  logic               o_frame_strobe;
  logic [15:0]        o_underrun_cnt;

  always #5 i_ddr_clk = ~i_ddr_clk;

  lvds_tx_framer dut (
    .i_ddr_clk     (i_ddr_clk),
    .i_rst         (i_rst),
    .o_ddr_data    (o_ddr_data),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_data   (i_fifo_data),
    .o_fifo_pull   (o_fifo_pull),
    .i_sample_gap  (i_sample_gap),
    .i_tx_en       (i_tx_en),
`ifdef LVDS_TX_LOOPBACK_EN
    .i_debug_lb    (i_debug_lb),
`endif
    .o_tx_state    (o_tx_state),
    .o_frame_strobe(o_frame_strobe),
    .o_underrun_cnt(o_underrun_cnt)
  );

  // Reference model, tracked per frame: what is on the wire and what comes next.
  int          m_mode, m_sync_sent, m_gap_left, m_pos, m_under;
  bit          m_started;
  logic [31:0] m_frame, m_next;
  logic [31:0] fifo_q[$];
  int          pulls;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic model_reset();
    m_mode      = M_SYNC;
    m_sync_sent = 1;
    m_gap_left  = 0;
    m_pos       = 0;
    m_frame     = '0;
    m_started   = 0;
    m_under     = 0;
  endtask

  task automatic restart_sync();
    m_mode      = M_SYNC;
    m_sync_sent = 1;
  endtask

  task automatic take_word(output bit p);
    m_next     = fifo_q[0];
    p          = 1;
    m_gap_left = int'(i_sample_gap);
    m_mode     = (i_sample_gap == 0) ? M_TX : M_GAP;
  endtask

  // Decide the next frame from the current inputs; runs in the last cycle of a frame.
  task automatic model_boundary(output bit pull_e);
    pull_e = 0;
    m_next = '0;
    case (m_mode)
      M_SYNC: begin
        if (m_sync_sent < SYNC_FRAMES) m_sync_sent++;
        else if (i_tx_en && fifo_q.size() != 0) take_word(pull_e);
        else if (i_debug_lb && !i_tx_en) begin
          m_mode = M_LB;
          m_next = LB_WORD;
        end else m_sync_sent = 1;
      end
      M_TX: begin
        if (!i_tx_en) restart_sync();
        else if (fifo_q.size() != 0) take_word(pull_e);
        else begin
          if (m_under < 65535) m_under++;
          restart_sync();
        end
      end
      M_GAP: begin
        if (!i_tx_en) restart_sync();
        else begin
          m_gap_left--;
          if (m_gap_left == 0) m_mode = M_TX;
        end
      end
      M_LB: begin
        if (i_debug_lb && !i_tx_en) m_next = LB_WORD;
        else restart_sync();
      end
      default: restart_sync();
    endcase
  endtask

  // One clock: compare at the falling edge, advance model and FIFO just after the rising edge.
  task automatic tick();
    bit bnd, exp_pull, got_pull;
    @(negedge i_ddr_clk);
    check("lanes", o_ddr_data, (m_frame >> (FRAME_W - LANES * (m_pos + 1))) & 32'h3);
    check("strobe", o_frame_strobe, (m_pos == 0 && m_started));
    check("tx_state", o_tx_state, (m_mode == M_TX || m_mode == M_GAP));
    check("underruns", o_underrun_cnt, m_under);
    bnd      = (m_pos == PHASES - 1);
    exp_pull = 0;
    if (bnd) model_boundary(exp_pull);
    got_pull = o_fifo_pull;
    check("pull", got_pull, exp_pull);
    if (got_pull) check("pull_nonempty", (fifo_q.size() != 0), 1);
    @(posedge i_ddr_clk);
    #1;
    if (got_pull && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pulls++;
    end
    drive_fifo();
    if (bnd) begin
      m_frame   = m_next;
      m_pos     = 0;
      m_started = 1;
    end else m_pos++;
  endtask

  task automatic run_frames(input int n);
    repeat (n * PHASES) tick();
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    #1;
    check("rst_lanes", o_ddr_data, 0);
    check("rst_strobe", o_frame_strobe, 0);
    check("rst_pull", o_fifo_pull, 0);
    check("rst_tx_state", o_tx_state, 0);
    check("rst_underruns", o_underrun_cnt, 0);
    repeat (2) @(posedge i_ddr_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    drive_fifo();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int  sz;
    bit  hit;
    i_rst        = 1'b1;
    i_tx_en      = 1'b0;
    i_debug_lb   = 1'b0;
    i_sample_gap = '0;
    pulls        = 0;
    drive_fifo();
    @(posedge i_ddr_clk);
    #1;
    apply_reset();

    // Idle: zero lanes, strobe every frame, no pulls.
    run_frames(40);
    check("t1_pulls", pulls, 0);

    // Two back-to-back words, then underrun back to SYNC.
    fifo_q.push_back(32'hA5A5_0F0F);
    fifo_q.push_back(32'h1234_5678);
    drive_fifo();
    i_sample_gap = '0;
    i_tx_en      = 1'b1;
    run_frames(14);
    check("t2_pulls", pulls, 2);
    check("t2_underrun", o_underrun_cnt, 1);
    run_frames(2);

    // Gap of three zero frames after each of four random words.
    i_tx_en = 1'b0;
    apply_reset();
    pulls        = 0;
    i_sample_gap = GAP_W'(3);
    push_words(4);
    i_tx_en = 1'b1;
    run_frames(30);
    check("t3_pulls", pulls, 4);

    // Enable drops at phase 7 of a data frame: that frame completes, then zeros.
    i_sample_gap = '0;
    push_words(6);
    hit = 0;
    for (int i = 0; i < 30 * PHASES && !hit; i++) begin
      tick();
      if (m_mode == M_TX && m_pos == 7 && m_frame != 0) hit = 1;
    end
    check("t4_reached", hit, 1);
    i_tx_en = 1'b0;
    run_frames(3);
    check("t4_tx_state", o_tx_state, 0);

    // Reset at phase 5 of a data frame: lanes clear at once, no extra pop.
    fifo_q.delete();
    push_words(4);
    i_tx_en = 1'b1;
    hit = 0;
    for (int i = 0; i < 30 * PHASES && !hit; i++) begin
      tick();
      if (m_mode == M_TX && m_pos == 5 && m_frame != 0) hit = 1;
    end
    check("t5_reached", hit, 1);
    sz = fifo_q.size();
    apply_reset();
    check("t5_no_pull", fifo_q.size(), sz);
    run_frames(14);

`ifdef LVDS_TX_LOOPBACK_EN
    // Loopback pattern after sync, then TX takes over.
    fifo_q.delete();
    drive_fifo();
    i_tx_en    = 1'b0;
    i_debug_lb = 1'b1;
    apply_reset();
    run_frames(16);
    push_words(3);
    i_tx_en = 1'b1;
    run_frames(16);
    i_debug_lb = 1'b0;
`endif

    // Random soak: sporadic words, gap changes and enable toggles at any phase.
    for (int c = 0; c < 150 * PHASES; c++) begin
      if ($urandom_range(0, 15) == 0 && fifo_q.size() < 8) push_words(1);
      if ($urandom_range(0, 199) == 0) i_tx_en = ~i_tx_en;
      if ($urandom_range(0, 63) == 0) i_sample_gap = GAP_W'($urandom_range(0, 2));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
